// File: rtl/tb_phase_sched_if.sv
// Handshake bundle between the phase scheduler, the directed-stimulus generators and the bench monitor.
// The stimulus side (master) drives go/phase_done/ev_reg/ev_cov; the scheduler (slave) drives the rest.
interface tb_phase_sched_if #(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 16
);
    localparam int ID_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    logic              go;
    logic              phase_done;
    logic              ev_reg;
    logic              ev_cov;
    logic              phase_start;
    logic [ID_W-1:0]   phase_id;
    logic              busy;
    logic              pass;
    logic              fail;
    logic [1:0]        fail_code;
    logic [CNT_W-1:0]  events_total;
    logic [CNT_W-1:0]  covered_total;

    modport master (
        output go, phase_done, ev_reg, ev_cov,
        input  phase_start, phase_id, busy, pass, fail, fail_code,
               events_total, covered_total
    );

    modport slave (
        input  go, phase_done, ev_reg, ev_cov,
        output phase_start, phase_id, busy, pass, fail, fail_code,
               events_total, covered_total
    );
endinterface

// File: rtl/tb_phase_sched.sv
// Test-phase scheduler: launches NUM_PHASES phases, tallies event/coverage pulses per phase,
// guards each phase with a watchdog and latches a sticky pass/fail verdict with a failure code.
module tb_phase_sched #(
    parameter int NUM_PHASES = 4,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    tb_phase_sched_if.slave      bus
);
    localparam int ID_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_PHASES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state_q;
    logic             phase_start_q;
    logic [ID_W-1:0]  phase_id_q;
    logic             busy_q;
    logic             pass_q;
    logic             fail_q;
    logic [1:0]       fail_code_q;
    logic [CNT_W-1:0] events_total_q;
    logic [CNT_W-1:0] covered_total_q;
    logic [CNT_W-1:0] phase_ev_q;
    logic [CNT_W-1:0] phase_cov_q;
    logic [WD_W-1:0]  wd_q;

    // Counters stick at all-ones so a flood of pulses can never wrap back to a "clean" value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            phase_start_q   <= 1'b0;
            phase_id_q      <= '0;
            busy_q          <= 1'b0;
            pass_q          <= 1'b0;
            fail_q          <= 1'b0;
            fail_code_q     <= 2'd0;
            events_total_q  <= '0;
            covered_total_q <= '0;
            phase_ev_q      <= '0;
            phase_cov_q     <= '0;
            wd_q            <= '0;
        end else begin
            phase_start_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (bus.go) begin
                        state_q         <= S_LAUNCH;
                        phase_start_q   <= 1'b1;
                        phase_id_q      <= '0;
                        busy_q          <= 1'b1;
                        pass_q          <= 1'b0;
                        fail_q          <= 1'b0;
                        fail_code_q     <= 2'd0;
                        events_total_q  <= '0;
                        covered_total_q <= '0;
                        phase_ev_q      <= '0;
                        phase_cov_q     <= '0;
                        wd_q            <= '0;
                    end
                end
                S_LAUNCH: begin
                    phase_ev_q  <= '0;
                    phase_cov_q <= '0;
                    wd_q        <= '0;
                    state_q     <= S_RUN;
                end
                S_RUN: begin
                    if (bus.ev_reg) begin
                        phase_ev_q     <= sat_inc(phase_ev_q);
                        events_total_q <= sat_inc(events_total_q);
                    end
                    if (bus.ev_cov) begin
                        phase_cov_q     <= sat_inc(phase_cov_q);
                        covered_total_q <= sat_inc(covered_total_q);
                    end
                    // A completion arriving on the watchdog's last cycle still counts as on time.
                    if (bus.phase_done) begin
                        state_q <= S_CHECK;
                    end else if (wd_q == WD_LAST) begin
                        state_q     <= S_ERROR;
                        busy_q      <= 1'b0;
                        fail_q      <= 1'b1;
                        fail_code_q <= 2'd1;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
                S_CHECK: begin
                    if (phase_ev_q == '0) begin
                        state_q     <= S_ERROR;
                        busy_q      <= 1'b0;
                        fail_q      <= 1'b1;
                        fail_code_q <= 2'd2;
                    end else if (phase_cov_q != phase_ev_q) begin
                        state_q     <= S_ERROR;
                        busy_q      <= 1'b0;
                        fail_q      <= 1'b1;
                        fail_code_q <= 2'd3;
                    end else if (phase_id_q == LAST_ID) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b1;
                    end else begin
                        state_q       <= S_LAUNCH;
                        phase_start_q <= 1'b1;
                        phase_id_q    <= phase_id_q + ID_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.phase_start   = phase_start_q;
    assign bus.phase_id      = phase_id_q;
    assign bus.busy          = busy_q;
    assign bus.pass          = pass_q;
    assign bus.fail          = fail_q;
    assign bus.fail_code     = fail_code_q;
    assign bus.events_total  = events_total_q;
    assign bus.covered_total = covered_total_q;
endmodule

// File: tb/tb_tb_phase_sched.sv
// Self-checking bench for tb_phase_sched: a 4-phase/TIMEOUT=16 instance and a 1-phase/CNT_W=4 instance,
// driven on negedges and compared against a phase-level outcome model.
module tb_tb_phase_sched;
    localparam int NP   = 4;
    localparam int TO   = 16;
    localparam int CW   = 16;
    localparam int TO_B = 40;
    localparam int CW_B = 4;
    localparam int SAT_B = (1 << CW_B) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tb_phase_sched_if #(.NUM_PHASES(NP), .CNT_W(CW))   a_if ();
    tb_phase_sched_if #(.NUM_PHASES(1),  .CNT_W(CW_B)) b_if ();

    tb_phase_sched #(.NUM_PHASES(NP), .TIMEOUT(TO), .CNT_W(CW)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    tb_phase_sched #(.NUM_PHASES(1), .TIMEOUT(TO_B), .CNT_W(CW_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Per-phase plan: done cycle index (len), whether done is ever given, and pulse bits per RUN cycle.
    int          len_a  [NP];
    bit          done_a [NP];
    bit [TO-1:0] reg_a  [NP];
    bit [TO-1:0] cov_a  [NP];

    bit exp_pass;
    int exp_code, exp_id, exp_ev, exp_cov, exp_starts;

    int obs_starts;
    int obs_id [NP];
    bit obs_run_bad;
    bit obs_start_bad;

    task automatic plan_phase(input int p, input int len, input bit done, input int nr, input int nc);
        len_a[p]  = len;
        done_a[p] = done;
        reg_a[p]  = '0;
        cov_a[p]  = '0;
        for (int k = 0; k < nr; k++) reg_a[p][k] = 1'b1;
        for (int k = 0; k < nc; k++) cov_a[p][k] = 1'b1;
    endtask

    // Outcome of a whole run from the plan: a phase lasts len+1 RUN cycles, or TO cycles if never done.
    task automatic model_a();
        int te, tc, nc, e, c;
        te = 0; tc = 0;
        exp_pass = 1'b0; exp_code = 0; exp_starts = 0; exp_id = 0;
        for (int p = 0; p < NP; p++) begin
            nc = done_a[p] ? len_a[p] + 1 : TO;
            e = 0; c = 0;
            for (int k = 0; k < nc; k++) begin
                e += int'(reg_a[p][k]);
                c += int'(cov_a[p][k]);
            end
            te += e; tc += c;
            exp_starts++;
            exp_id = p;
            if (!done_a[p]) begin exp_code = 1; break; end
            if (e == 0)     begin exp_code = 2; break; end
            if (c != e)     begin exp_code = 3; break; end
            if (p == NP - 1) exp_pass = 1'b1;
        end
        exp_ev  = te;
        exp_cov = tc;
    endtask

    // Drives one run of dut_a from the plan and records what it observed; leaves the bench at the verdict cycle.
    task automatic drive_run();
        int n;
        obs_starts = 0; obs_run_bad = 1'b0; obs_start_bad = 1'b0;
        for (int p = 0; p < NP; p++) obs_id[p] = -1;
        @(negedge clk); a_if.go = 1'b1;
        @(negedge clk); a_if.go = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (a_if.phase_start !== 1'b1) begin obs_start_bad = 1'b1; break; end
            obs_starts++;
            obs_id[p] = int'(a_if.phase_id);
            @(negedge clk);
            n = done_a[p] ? len_a[p] + 1 : TO;
            for (int c = 0; c < n; c++) begin
                if (a_if.busy !== 1'b1 || a_if.pass !== 1'b0 || a_if.fail !== 1'b0 || a_if.phase_start !== 1'b0)
                    obs_run_bad = 1'b1;
                a_if.ev_reg     = reg_a[p][c];
                a_if.ev_cov     = cov_a[p][c];
                a_if.phase_done = done_a[p] && (c == len_a[p]);
                @(negedge clk);
            end
            a_if.ev_reg = 1'b0; a_if.ev_cov = 1'b0; a_if.phase_done = 1'b0;
            if (!done_a[p]) break;
            @(negedge clk);
            if (a_if.pass === 1'b1 || a_if.fail === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_if.phase_start, a_if.phase_id, a_if.busy, a_if.pass, a_if.fail, a_if.fail_code,
             a_if.events_total, a_if.covered_total} !== '0) begin
            failures++;
            $display("FAIL reset_a outputs got=%0h required=0", {a_if.phase_start, a_if.phase_id, a_if.busy,
                     a_if.pass, a_if.fail, a_if.fail_code, a_if.events_total, a_if.covered_total});
        end
        checks++;
        if ({b_if.phase_start, b_if.phase_id, b_if.busy, b_if.pass, b_if.fail, b_if.fail_code,
             b_if.events_total, b_if.covered_total} !== '0) begin
            failures++;
            $display("FAIL reset_b outputs got=%0h required=0", {b_if.phase_start, b_if.phase_id, b_if.busy,
                     b_if.pass, b_if.fail, b_if.fail_code, b_if.events_total, b_if.covered_total});
        end
        rst = 1'b0;
        @(negedge clk);
        $display("reset: checked both instances idle");
    endtask

    task automatic test_nominal();
        for (int p = 0; p < NP; p++) plan_phase(p, 3, 1'b1, 3, 3);
        drive_run();
        checks++;
        if (obs_starts !== 4 || obs_start_bad || obs_run_bad) begin
            failures++;
            $display("FAIL nominal_starts got=%0d bad=%0b/%0b required=4", obs_starts, obs_start_bad, obs_run_bad);
        end
        for (int p = 0; p < NP; p++) begin
            checks++;
            if (obs_id[p] !== p) begin
                failures++;
                $display("FAIL nominal_phase_id[%0d] got=%0d required=%0d", p, obs_id[p], p);
            end
        end
        checks++;
        if (a_if.pass !== 1'b1 || a_if.fail !== 1'b0 || a_if.fail_code !== 2'd0 || a_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL nominal_verdict got pass=%0b fail=%0b code=%0d busy=%0b required 1/0/0/0",
                     a_if.pass, a_if.fail, a_if.fail_code, a_if.busy);
        end
        checks++;
        if (a_if.events_total !== 16'd12 || a_if.covered_total !== 16'd12) begin
            failures++;
            $display("FAIL nominal_totals got=%0d/%0d required=12/12", a_if.events_total, a_if.covered_total);
        end
        $display("nominal: 4 phases x 3/3 pass=%0b totals=%0d/%0d", a_if.pass, a_if.events_total, a_if.covered_total);
    endtask

    task automatic test_timeout();
        plan_phase(0, 0, 1'b0, 2, 2);
        drive_run();
        checks++;
        if (obs_run_bad !== 1'b0 || obs_starts !== 1) begin
            failures++;
            $display("FAIL timeout_early got run_bad=%0b starts=%0d required 0/1", obs_run_bad, obs_starts);
        end
        checks++;
        if (a_if.fail !== 1'b1 || a_if.fail_code !== 2'd1 || a_if.pass !== 1'b0) begin
            failures++;
            $display("FAIL timeout_verdict got fail=%0b code=%0d pass=%0b required 1/1/0",
                     a_if.fail, a_if.fail_code, a_if.pass);
        end
        checks++;
        if (a_if.phase_id !== 2'd0 || a_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_id_busy got id=%0d busy=%0b required 0/0", a_if.phase_id, a_if.busy);
        end
        $display("timeout: fail=%0b code=%0d after %0d RUN cycles", a_if.fail, a_if.fail_code, TO);
    endtask

    task automatic test_mismatch();
        plan_phase(0, 3, 1'b1, 3, 3);
        plan_phase(1, 5, 1'b1, 5, 4);
        plan_phase(2, 3, 1'b1, 3, 3);
        plan_phase(3, 3, 1'b1, 3, 3);
        drive_run();
        checks++;
        if (a_if.fail !== 1'b1 || a_if.fail_code !== 2'd3 || a_if.phase_id !== 2'd1) begin
            failures++;
            $display("FAIL mismatch_verdict got fail=%0b code=%0d id=%0d required 1/3/1",
                     a_if.fail, a_if.fail_code, a_if.phase_id);
        end
        checks++;
        if (a_if.events_total !== 16'd8 || a_if.covered_total !== 16'd7) begin
            failures++;
            $display("FAIL mismatch_totals got=%0d/%0d required=8/7", a_if.events_total, a_if.covered_total);
        end
        checks++;
        if (obs_starts !== 2) begin
            failures++;
            $display("FAIL mismatch_starts got=%0d required=2", obs_starts);
        end
        $display("mismatch: code=%0d id=%0d totals=%0d/%0d", a_if.fail_code, a_if.phase_id,
                 a_if.events_total, a_if.covered_total);
    endtask

    task automatic test_zero_events();
        plan_phase(0, 2, 1'b1, 0, 0);
        drive_run();
        checks++;
        if (a_if.fail !== 1'b1 || a_if.fail_code !== 2'd2 || a_if.phase_id !== 2'd0 || obs_starts !== 1) begin
            failures++;
            $display("FAIL zero_events got fail=%0b code=%0d id=%0d starts=%0d required 1/2/0/1",
                     a_if.fail, a_if.fail_code, a_if.phase_id, obs_starts);
        end
        $display("zero_events: code=%0d", a_if.fail_code);
        for (int p = 0; p < NP; p++) plan_phase(p, 0, 1'b1, 1, 1);
        drive_run();
        checks++;
        if (a_if.pass !== 1'b1 || a_if.fail !== 1'b0 || a_if.events_total !== 16'd4 || a_if.covered_total !== 16'd4) begin
            failures++;
            $display("FAIL same_cycle got pass=%0b fail=%0b totals=%0d/%0d required 1/0/4/4",
                     a_if.pass, a_if.fail, a_if.events_total, a_if.covered_total);
        end
        $display("same_cycle: pass=%0b totals=%0d/%0d", a_if.pass, a_if.events_total, a_if.covered_total);
    endtask

    task automatic test_done_at_limit();
        plan_phase(0, TO - 1, 1'b1, 2, 2);
        for (int p = 1; p < NP; p++) plan_phase(p, 1, 1'b1, 1, 1);
        drive_run();
        checks++;
        if (a_if.pass !== 1'b1 || a_if.fail_code !== 2'd0 || a_if.events_total !== 16'd5) begin
            failures++;
            $display("FAIL done_at_limit got pass=%0b code=%0d ev=%0d required 1/0/5",
                     a_if.pass, a_if.fail_code, a_if.events_total);
        end
        $display("done_at_limit: pass=%0b code=%0d", a_if.pass, a_if.fail_code);
    endtask

    task automatic test_random();
        int mode;
        for (int r = 0; r < 12; r++) begin
            for (int p = 0; p < NP; p++) begin
                mode      = $urandom_range(0, 9);
                len_a[p]  = $urandom_range(0, TO - 1);
                done_a[p] = (mode != 9);
                reg_a[p]  = TO'($urandom());
                cov_a[p]  = (mode < 7) ? reg_a[p] : TO'($urandom());
            end
            model_a();
            drive_run();
            checks++;
            if (a_if.pass !== exp_pass || a_if.fail !== (exp_code != 0) || a_if.fail_code !== 2'(exp_code)) begin
                failures++;
                $display("FAIL random[%0d]_verdict got pass=%0b fail=%0b code=%0d required %0b/%0b/%0d",
                         r, a_if.pass, a_if.fail, a_if.fail_code, exp_pass, exp_code != 0, exp_code);
            end
            checks++;
            if (a_if.phase_id !== 2'(exp_id) || obs_starts !== exp_starts || obs_run_bad) begin
                failures++;
                $display("FAIL random[%0d]_phases got id=%0d starts=%0d run_bad=%0b required %0d/%0d/0",
                         r, a_if.phase_id, obs_starts, obs_run_bad, exp_id, exp_starts);
            end
            checks++;
            if (a_if.events_total !== 16'(exp_ev) || a_if.covered_total !== 16'(exp_cov)) begin
                failures++;
                $display("FAIL random[%0d]_totals got=%0d/%0d required=%0d/%0d",
                         r, a_if.events_total, a_if.covered_total, exp_ev, exp_cov);
            end
            $display("random[%0d]: pass=%0b code=%0d id=%0d totals=%0d/%0d", r, a_if.pass,
                     a_if.fail_code, a_if.phase_id, a_if.events_total, a_if.covered_total);
        end
    endtask

    task automatic test_mid_run_reset();
        @(negedge clk); a_if.go = 1'b1;
        @(negedge clk); a_if.go = 1'b0;
        for (int p = 0; p < 2; p++) begin
            @(negedge clk); a_if.ev_reg = 1'b1; a_if.ev_cov = 1'b1;
            @(negedge clk); a_if.ev_reg = 1'b0; a_if.ev_cov = 1'b0; a_if.phase_done = 1'b1;
            @(negedge clk); a_if.phase_done = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (a_if.phase_start !== 1'b1 || a_if.phase_id !== 2'd2) begin
            failures++;
            $display("FAIL midrst_phase2 got start=%0b id=%0d required 1/2", a_if.phase_start, a_if.phase_id);
        end
        @(negedge clk); a_if.ev_reg = 1'b1; a_if.go = 1'b1;
        @(negedge clk); a_if.ev_reg = 1'b0; a_if.go = 1'b0;
        checks++;
        if (a_if.phase_start !== 1'b0 || a_if.busy !== 1'b1 || a_if.events_total !== 16'd3 || a_if.covered_total !== 16'd2) begin
            failures++;
            $display("FAIL go_ignored got start=%0b busy=%0b totals=%0d/%0d required 0/1/3/2",
                     a_if.phase_start, a_if.busy, a_if.events_total, a_if.covered_total);
        end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checks++;
        if ({a_if.phase_start, a_if.phase_id, a_if.busy, a_if.pass, a_if.fail, a_if.fail_code,
             a_if.events_total, a_if.covered_total} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got=%0h required=0", {a_if.phase_start, a_if.phase_id, a_if.busy,
                     a_if.pass, a_if.fail, a_if.fail_code, a_if.events_total, a_if.covered_total});
        end
        @(negedge clk);
        checks++;
        if (a_if.busy !== 1'b0 || a_if.phase_start !== 1'b0) begin
            failures++;
            $display("FAIL midrst_idle got busy=%0b start=%0b required 0/0", a_if.busy, a_if.phase_start);
        end
        $display("mid_run_reset: outputs cleared, go while busy ignored");
        for (int p = 0; p < NP; p++) plan_phase(p, 1, 1'b1, 1, 1);
        drive_run();
        checks++;
        if (a_if.pass !== 1'b1 || a_if.events_total !== 16'd4) begin
            failures++;
            $display("FAIL restart_done got pass=%0b ev=%0d required 1/4", a_if.pass, a_if.events_total);
        end
        @(negedge clk); a_if.go = 1'b1;
        @(negedge clk); a_if.go = 1'b0;
        checks++;
        if (a_if.phase_start !== 1'b1 || a_if.phase_id !== 2'd0 || a_if.events_total !== 16'd0 ||
            a_if.covered_total !== 16'd0 || a_if.pass !== 1'b0 || a_if.busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_cleared got start=%0b id=%0d totals=%0d/%0d pass=%0b busy=%0b required 1/0/0/0/0/1",
                     a_if.phase_start, a_if.phase_id, a_if.events_total, a_if.covered_total, a_if.pass, a_if.busy);
        end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        $display("restart: go after DONE cleared totals");
    endtask

    task automatic test_saturation();
        int nr, nc, n, pe, pc, code;
        for (int t = 0; t < 5; t++) begin
            if (t < 2) begin nr = 20; nc = (t == 0) ? 20 : 17; end
            else begin nr = $urandom_range(0, 25); nc = $urandom_range(0, 25); end
            pe   = (nr > SAT_B) ? SAT_B : nr;
            pc   = (nc > SAT_B) ? SAT_B : nc;
            code = (pe == 0) ? 2 : ((pe != pc) ? 3 : 0);
            n    = (nr > nc) ? nr : nc;
            @(negedge clk); b_if.go = 1'b1;
            @(negedge clk); b_if.go = 1'b0;
            checks++;
            if (b_if.phase_start !== 1'b1 || b_if.phase_id !== 1'b0) begin
                failures++;
                $display("FAIL sat[%0d]_start got start=%0b id=%0d required 1/0", t, b_if.phase_start, b_if.phase_id);
            end
            @(negedge clk);
            for (int c = 0; c < n; c++) begin
                b_if.ev_reg = (c < nr);
                b_if.ev_cov = (c < nc);
                @(negedge clk);
            end
            b_if.ev_reg = 1'b0; b_if.ev_cov = 1'b0; b_if.phase_done = 1'b1;
            @(negedge clk); b_if.phase_done = 1'b0;
            @(negedge clk);
            checks++;
            if (b_if.pass !== (code == 0) || b_if.fail !== (code != 0) || b_if.fail_code !== 2'(code)) begin
                failures++;
                $display("FAIL sat[%0d]_verdict got pass=%0b fail=%0b code=%0d required %0b/%0b/%0d",
                         t, b_if.pass, b_if.fail, b_if.fail_code, code == 0, code != 0, code);
            end
            checks++;
            if (b_if.events_total !== 4'(pe) || b_if.covered_total !== 4'(pc)) begin
                failures++;
                $display("FAIL sat[%0d]_totals got=%0d/%0d required=%0d/%0d",
                         t, b_if.events_total, b_if.covered_total, pe, pc);
            end
            $display("saturation[%0d]: reg=%0d cov=%0d -> totals=%0d/%0d code=%0d",
                     t, nr, nc, b_if.events_total, b_if.covered_total, b_if.fail_code);
        end
    endtask

    initial begin
        a_if.go = 1'b0; a_if.phase_done = 1'b0; a_if.ev_reg = 1'b0; a_if.ev_cov = 1'b0;
        b_if.go = 1'b0; b_if.phase_done = 1'b0; b_if.ev_reg = 1'b0; b_if.ev_cov = 1'b0;
        rst = 1'b1;
        test_reset();
        test_nominal();
        test_timeout();
        test_mismatch();
        test_zero_events();
        test_done_at_limit();
        test_random();
        test_mid_run_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "simulation time limit reached");
    end
endmodule
